// File: rtl/fetch_trace_pkg.sv
// Shared definitions for the fetch trace buffer.
// Holds the trace entry flag layout, field offsets, the entry width
// computation and the saturating increment used by the event counters.
// Entry layout, MSB to LSB: {pc, tval, inst, trap_en, bj_en, page_fault, invalid, cause[4:0]}
package fetch_trace_pkg;

    localparam int FLAG_W  = 9;
    localparam int CAUSE_W = 5;

    // Bit positions inside the low FLAG_W bits of an entry
    localparam int FLG_CAUSE_LSB = 0;
    localparam int FLG_INVALID   = 5;
    localparam int FLG_PF        = 6;
    localparam int FLG_BJ        = 7;
    localparam int FLG_TRAP      = 8;

    // Event counter indices
    localparam int NUM_CNT   = 5;
    localparam int CNT_FETCH = 0;
    localparam int CNT_TRAP  = 1;
    localparam int CNT_BJ    = 2;
    localparam int CNT_STALL = 3;
    localparam int CNT_PF    = 4;

    // Widest counter the saturating helper handles
    localparam int CNT_MAX_W = 64;

    typedef struct packed {
        logic                trap_en;
        logic                bj_en;
        logic                page_fault;
        logic                invalid;
        logic [CAUSE_W-1:0]  cause;
    } flags_t;

    function automatic int e_w(input int pc_w, input int inst_w);
        return 2 * pc_w + inst_w + FLAG_W;
    endfunction

    // Increment by inc, holding at max_v once reached
    function automatic logic [CNT_MAX_W-1:0] sat_inc(
        input logic [CNT_MAX_W-1:0] v,
        input logic [CNT_MAX_W-1:0] max_v,
        input logic                 inc
    );
        return (inc && (v != max_v)) ? v + 64'd1 : v;
    endfunction

endpackage

// File: rtl/fetch_trace_buf_fifo.sv
// trace_fifo: circular trace storage with stop-when-full or overwrite-oldest.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             synchronous clear of pointers, count and overflow
//   wrap            0: drop when full; 1: overwrite oldest when full
//   push, wr_data   write request and entry
//   rd_valid/rd_ready/rd_data  readout; pop when rd_valid & rd_ready
//   count           entries held
//   overflow        sticky: an entry was dropped or overwritten
// Memory is not reset; rd_data is forced to zero while empty.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int E_W   = 169
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wrap,
    input  logic                         push,
    input  logic [E_W-1:0]               wr_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [E_W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [E_W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           pop;
    logic           wr_norm;    // write that occupies a free (or freed) slot
    logic           wr_over;    // full, no pop, wrap: replace the oldest entry

    assign full     = (count == CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    assign wr_norm  = push & (~full | pop);
    assign wr_over  = push & full & ~pop & wrap;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!clr && (wr_norm || wr_over)) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural rollover
            if (wr_norm || wr_over) wr_ptr <= wr_ptr + AW'(1);
            if (pop || wr_over)     rd_ptr <= rd_ptr + AW'(1);
            if (push && full && !pop) overflow <= 1'b1;
            case ({wr_norm, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_trace_buf.sv
// fetch_trace_buf: captures fetch-stage events into a circular trace buffer.
// Read-only toward the pipeline. Filters captures by an inclusive PC window,
// can freeze capture after a captured trap, and keeps saturating event counters.
// Ports:
//   clk, rst, clr                    clock, async reset, synchronous clear
//   cfg_en, cfg_wrap, cfg_freeze_on_trap, cfg_pc_lo, cfg_pc_hi   configuration
//   pc, inst, trap_en, bj_en, stall, page_fault, invalid, cause, tval   fetch status
//   rd_valid, rd_ready, rd_data      oldest-entry readout (valid/ready)
//   count, overflow, frozen          buffer status
//   cnt_fetch .. cnt_pf              saturating event counters
module fetch_trace_buf
    import fetch_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 64,
    parameter int INST_W = 32,
    parameter int CNT_W  = 32,
    parameter int E_W    = e_w(PC_W, INST_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        cfg_en,
    input  logic                        cfg_wrap,
    input  logic                        cfg_freeze_on_trap,
    input  logic [PC_W-1:0]             cfg_pc_lo,
    input  logic [PC_W-1:0]             cfg_pc_hi,
    input  logic [PC_W-1:0]             pc,
    input  logic [INST_W-1:0]           inst,
    input  logic                        trap_en,
    input  logic                        bj_en,
    input  logic                        stall,
    input  logic                        page_fault,
    input  logic                        invalid,
    input  logic [4:0]                  cause,
    input  logic [PC_W-1:0]             tval,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [E_W-1:0]              rd_data,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        overflow,
    output logic                        frozen,
    output logic [CNT_W-1:0]            cnt_fetch,
    output logic [CNT_W-1:0]            cnt_trap,
    output logic [CNT_W-1:0]            cnt_bj,
    output logic [CNT_W-1:0]            cnt_stall,
    output logic [CNT_W-1:0]            cnt_pf
);

    localparam logic [CNT_MAX_W-1:0] CNT_MAX = CNT_MAX_W'({CNT_W{1'b1}});

    logic               in_window;
    logic               cap;
    flags_t             flags;
    logic [E_W-1:0]     entry;
    logic [NUM_CNT-1:0] ev;
    logic [CNT_W-1:0]   cnt_q [NUM_CNT];

    // An inverted window (lo > hi) can never satisfy both bounds
    assign in_window = (pc >= cfg_pc_lo) && (pc <= cfg_pc_hi);
    assign cap       = cfg_en & ~frozen & ~stall & in_window;

    assign flags.trap_en    = trap_en;
    assign flags.bj_en      = bj_en;
    assign flags.page_fault = page_fault;
    assign flags.invalid    = invalid;
    assign flags.cause      = cause;
    assign entry            = {pc, tval, inst, flags};

    trace_fifo #(
        .DEPTH (DEPTH),
        .E_W   (E_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wrap     (cfg_wrap),
        .push     (cap),
        .wr_data  (entry),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow)
    );

    // The trap entry itself is written on the same edge that sets frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frozen <= 1'b0;
        end else if (clr) begin
            frozen <= 1'b0;
        end else if (cap && trap_en && cfg_freeze_on_trap) begin
            frozen <= 1'b1;
        end
    end

    // Counters observe every fetch while enabled, independent of window and freeze
    always_comb begin
        ev            = '0;
        ev[CNT_FETCH] = ~stall & ~invalid;
        ev[CNT_TRAP]  = trap_en;
        ev[CNT_BJ]    = bj_en;
        ev[CNT_STALL] = stall;
        ev[CNT_PF]    = page_fault;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
        end else if (cfg_en) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= CNT_W'(sat_inc(CNT_MAX_W'(cnt_q[i]), CNT_MAX, ev[i]));
            end
        end
    end

    assign cnt_fetch = cnt_q[CNT_FETCH];
    assign cnt_trap  = cnt_q[CNT_TRAP];
    assign cnt_bj    = cnt_q[CNT_BJ];
    assign cnt_stall = cnt_q[CNT_STALL];
    assign cnt_pf    = cnt_q[CNT_PF];

endmodule

// File: tb/tb_fetch_trace_buf.sv
// Directed bench for fetch_trace_buf with DEPTH=4 and 4-bit counters.
module tb_fetch_trace_buf;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int CNT_W  = 4;
  localparam int E_W    = 2*PC_W + INST_W + 9;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 0;
  logic              rst = 0;
  logic              clr = 0;
  logic              cfg_en = 0;
  logic              cfg_wrap = 0;
  logic              cfg_freeze_on_trap = 0;
  logic [PC_W-1:0]   cfg_pc_lo = 64'h1000;
  logic [PC_W-1:0]   cfg_pc_hi = 64'h1FFF;
  logic [PC_W-1:0]   pc = 0;
  logic [INST_W-1:0] inst = 0;
  logic              trap_en = 0, bj_en = 0, stall = 0, page_fault = 0, invalid = 1;
  logic [4:0]        cause = 0;
  logic [PC_W-1:0]   tval = 0;
  logic              rd_valid;
  logic              rd_ready = 0;
  logic [E_W-1:0]    rd_data;
  logic [CW-1:0]     count;
  logic              overflow, frozen;
  logic [CNT_W-1:0]  cnt_fetch, cnt_trap, cnt_bj, cnt_stall, cnt_pf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0]    exp_q[$];
  logic [E_W-1:0] last_entry;

  fetch_trace_buf #(
    .DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .cfg_en(cfg_en), .cfg_wrap(cfg_wrap), .cfg_freeze_on_trap(cfg_freeze_on_trap),
    .cfg_pc_lo(cfg_pc_lo), .cfg_pc_hi(cfg_pc_hi),
    .pc(pc), .inst(inst), .trap_en(trap_en), .bj_en(bj_en), .stall(stall),
    .page_fault(page_fault), .invalid(invalid), .cause(cause), .tval(tval),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .overflow(overflow), .frozen(frozen),
    .cnt_fetch(cnt_fetch), .cnt_trap(cnt_trap), .cnt_bj(cnt_bj),
    .cnt_stall(cnt_stall), .cnt_pf(cnt_pf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // entry field views, layout {pc, tval, inst, trap, bj, pf, inv, cause}
  function automatic logic [63:0] f_pc(input logic [E_W-1:0] e);
    return e[E_W-1 -: 64];
  endfunction
  function automatic logic [63:0] f_inst(input logic [E_W-1:0] e);
    return 64'(e[9 +: INST_W]);
  endfunction
  function automatic logic [63:0] f_cause(input logic [E_W-1:0] e);
    return 64'(e[4:0]);
  endfunction
  function automatic logic [63:0] f_trap(input logic [E_W-1:0] e);
    return 64'(e[8]);
  endfunction

  // driver tasks
  task automatic set_idle();
    pc = 0; inst = 0; trap_en = 0; bj_en = 0; stall = 0;
    page_fault = 0; invalid = 1; cause = 0; tval = 0;
  endtask

  task automatic set_fetch(input logic [63:0] p, input logic trap, input logic [4:0] c,
                           input logic stl);
    pc = p; inst = p[31:0] ^ 32'hA5A5_0000; trap_en = trap; bj_en = 0; stall = stl;
    page_fault = 0; invalid = 0; cause = c; tval = trap ? p : 64'h0;
  endtask

  task automatic fetch(input logic [63:0] p, input logic trap, input logic [4:0] c,
                       input logic stl);
    set_fetch(p, trap, c, stl);
    tick();
    set_idle();
  endtask

  task automatic do_clr();
    clr = 1;
    tick();
    clr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #12;
    rst = 0;
    tick();
  endtask

  // pop everything, comparing pc against the expected queue
  task automatic drain(input string tag);
    logic [63:0] exp_pc;
    rd_ready = 1;
    for (int i = 0; i < DEPTH + 4 && rd_valid; i++) begin
      exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
      check(tag, f_pc(rd_data), exp_pc);
      last_entry = rd_data;
      tick();
    end
    rd_ready = 0;
    check({tag, "_left"}, 64'(exp_q.size()), 64'h0);
    check({tag, "_empty"}, 64'(rd_valid), 64'h0);
  endtask

  initial begin
    set_idle();
    do_reset();

    // reset state
    check("rst_valid", 64'(rd_valid), 0);
    check("rst_count", 64'(count), 0);
    check("rst_ovf", 64'(overflow), 0);
    check("rst_frozen", 64'(frozen), 0);
    check("rst_cnt_fetch", 64'(cnt_fetch), 0);
    check("rst_data", f_pc(rd_data), 0);

    // disabled: nothing counted or captured
    fetch(64'h1000, 0, 0, 0);
    check("dis_count", 64'(count), 0);
    check("dis_cnt_fetch", 64'(cnt_fetch), 0);

    // window filter
    cfg_en = 1;
    set_fetch(64'h1000, 0, 0, 0);
    #1;
    check("nobypass_valid", 64'(rd_valid), 0);
    tick();
    set_idle();
    fetch(64'h0FFC, 0, 0, 0);
    fetch(64'h2000, 0, 0, 0);
    check("win_count", 64'(count), 1);
    check("win_cnt_fetch", 64'(cnt_fetch), 3);
    check("win_inst", f_inst(rd_data), 64'h0000_0000_A5A5_1000);
    exp_q.push_back(64'h1000);
    drain("win_drain");
    do_clr();
    check("clr_cnt_fetch", 64'(cnt_fetch), 0);

    // stop when full
    for (int i = 0; i < 6; i++) fetch(64'h1000 + 64'(4*i), 0, 0, 0);
    check("stop_count", 64'(count), 4);
    check("stop_ovf", 64'(overflow), 1);
    for (int i = 0; i < 4; i++) exp_q.push_back(64'h1000 + 64'(4*i));
    drain("stop_drain");
    do_clr();
    check("clr_ovf", 64'(overflow), 0);

    // overwrite oldest
    cfg_wrap = 1;
    for (int i = 0; i < 6; i++) fetch(64'h1000 + 64'(4*i), 0, 0, 0);
    check("wrap_count", 64'(count), 4);
    check("wrap_ovf", 64'(overflow), 1);
    for (int i = 2; i < 6; i++) exp_q.push_back(64'h1000 + 64'(4*i));
    drain("wrap_drain");
    do_clr();

    // full, capture with simultaneous pop
    cfg_wrap = 0;
    for (int i = 0; i < 4; i++) fetch(64'h1000 + 64'(4*i), 0, 0, 0);
    check("pp_full", 64'(count), 4);
    set_fetch(64'h1010, 0, 0, 0);
    rd_ready = 1;
    #1;
    check("pp_oldest", f_pc(rd_data), 64'h1000);
    tick();
    rd_ready = 0;
    set_idle();
    check("pp_count", 64'(count), 4);
    check("pp_ovf", 64'(overflow), 0);
    check("pp_head", f_pc(rd_data), 64'h1004);
    for (int i = 1; i < 5; i++) exp_q.push_back(64'h1000 + 64'(4*i));
    drain("pp_drain");
    do_clr();

    // freeze on trap
    cfg_freeze_on_trap = 1;
    fetch(64'h100C, 0, 0, 0);
    fetch(64'h1010, 1, 5'd5, 0);
    fetch(64'h1014, 0, 0, 0);
    fetch(64'h1018, 0, 0, 0);
    check("frz_frozen", 64'(frozen), 1);
    check("frz_count", 64'(count), 2);
    check("frz_cnt_fetch", 64'(cnt_fetch), 4);
    check("frz_cnt_trap", 64'(cnt_trap), 1);
    exp_q.push_back(64'h100C);
    exp_q.push_back(64'h1010);
    drain("frz_drain");
    check("frz_last_cause", f_cause(last_entry), 5);
    check("frz_last_trap", f_trap(last_entry), 1);
    check("frz_still", 64'(frozen), 1);
    fetch(64'h1020, 0, 0, 0);
    check("frz_blocked", 64'(count), 0);
    do_clr();
    check("frz_clr_frozen", 64'(frozen), 0);
    check("frz_clr_count", 64'(count), 0);
    check("frz_clr_fetch", 64'(cnt_fetch), 0);
    check("frz_clr_trap", 64'(cnt_trap), 0);
    cfg_freeze_on_trap = 0;

    // inverted window captures nothing
    cfg_pc_lo = 64'h2000;
    cfg_pc_hi = 64'h1000;
    fetch(64'h1800, 0, 0, 0);
    fetch(64'h2000, 0, 0, 0);
    check("inv_win_count", 64'(count), 0);
    cfg_pc_lo = 64'h1000;
    cfg_pc_hi = 64'h1FFF;

    // stall saturation
    do_clr();
    for (int i = 0; i < 20; i++) fetch(64'h1000, 0, 0, 1);
    check("sat_stall", 64'(cnt_stall), 15);
    check("sat_count", 64'(count), 0);
    check("sat_fetch", 64'(cnt_fetch), 0);

    // async reset mid-stream
    fetch(64'h1000, 0, 0, 0);
    set_fetch(64'h1004, 0, 0, 0);
    rd_ready = 1;
    check("pre_rst_count", 64'(count), 1);
    #2;
    rst = 1;
    #1;
    check("arst_valid", 64'(rd_valid), 0);
    check("arst_count", 64'(count), 0);
    check("arst_data", f_pc(rd_data), 0);
    check("arst_stall", 64'(cnt_stall), 0);
    check("arst_fetch", 64'(cnt_fetch), 0);
    check("arst_ovf", 64'(overflow), 0);
    rd_ready = 0;
    set_idle();
    #10;
    rst = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
